// File: rtl/hci_core_req_buffer.sv
// rtl/hci_core_req_buffer.sv - request FIFO with outstanding-transaction cap between core port and region demux
// Define HCI_REQ_BUFFER_BYPASS_EN for zero-latency issue when the FIFO is empty.

package hci_package;
  parameter int DEFAULT_AW  = 32;
  parameter int DEFAULT_DW  = 32;
  parameter int DEFAULT_UW  = 1;
  parameter int DEFAULT_BOW = 2;
endpackage

interface hci_core_intf #(
  parameter int AW  = hci_package::DEFAULT_AW,
  parameter int DW  = hci_package::DEFAULT_DW,
  parameter int UW  = hci_package::DEFAULT_UW,
  parameter int BOW = hci_package::DEFAULT_BOW
) ();
  logic              req;
  logic              gnt;
  logic [AW-1:0]     add;
  logic              wen;
  logic [DW-1:0]     data;
  logic [DW/8-1:0]   be;
  logic [BOW-1:0]    boffs;
  logic              lrdy;
  logic [DW-1:0]     r_data;
  logic              r_valid;
  logic              r_opc;
  logic [UW-1:0]     r_user;

  modport master (
    output req, add, wen, data, be, boffs, lrdy,
    input  gnt, r_data, r_valid, r_opc, r_user
  );
  modport slave (
    input  req, add, wen, data, be, boffs, lrdy,
    output gnt, r_data, r_valid, r_opc, r_user
  );
endinterface

module hci_core_req_buffer #(
  parameter int DEPTH           = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int AW              = hci_package::DEFAULT_AW,
  parameter int DW              = hci_package::DEFAULT_DW,
  parameter int UW              = hci_package::DEFAULT_UW
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               clear_i,
  hci_core_intf.slave                        slave,
  hci_core_intf.master                       master,
  output logic [$clog2(DEPTH):0]             count_o,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               err_o
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int OW  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int BW  = DW / 8;
  localparam int BOW = hci_package::DEFAULT_BOW;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [OW:0]   MAXO_C  = (OW+1)'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [AW-1:0]  add;
    logic           wen;
    logic [DW-1:0]  data;
    logic [BW-1:0]  be;
    logic [BOW-1:0] boffs;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [OW-1:0]   out_q, out_d;
  logic            err_q, err_d;

  entry_t          head, slv_entry, mst_entry;
  logic [OW:0]     inflight;
  logic            fifo_empty, fifo_gnt, bypass, issue, push, pop;

  assign inflight   = (OW+1)'(count_q) + (OW+1)'(out_q);
  assign fifo_empty = (count_q == '0);
  assign fifo_gnt   = (count_q < DEPTH_C) && (inflight < MAXO_C);

  assign head      = mem_q[rptr_q];
  assign slv_entry = '{add: slave.add, wen: slave.wen, data: slave.data,
                       be: slave.be, boffs: slave.boffs};

`ifdef HCI_REQ_BUFFER_BYPASS_EN
  assign bypass = fifo_empty && fifo_gnt;
`else
  assign bypass = 1'b0;
`endif

  assign mst_entry    = bypass ? slv_entry : head;
  assign master.req   = !fifo_empty || (bypass && slave.req);
  assign master.add   = mst_entry.add;
  assign master.wen   = mst_entry.wen;
  assign master.data  = mst_entry.data;
  assign master.be    = mst_entry.be;
  assign master.boffs = mst_entry.boffs;
  assign master.lrdy  = slave.lrdy;

  assign slave.gnt     = bypass ? master.gnt : fifo_gnt;
  assign slave.r_valid = master.r_valid;
  assign slave.r_data  = master.r_data;
  assign slave.r_opc   = master.r_opc;
  assign slave.r_user  = master.r_user;

  // A bypassed request is issued without ever occupying a FIFO slot.
  assign issue = master.req && master.gnt;
  assign push  = slave.req && slave.gnt && !bypass;
  assign pop   = issue && !fifo_empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    out_d   = out_q;
    err_d   = err_q;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (issue && !master.r_valid) begin
      out_d = out_q + OW'(1);
    end else if (!issue && master.r_valid) begin
      if (out_q == '0) err_d = 1'b1;
      else             out_d = out_q - OW'(1);
    end
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      out_d   = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= slv_entry;
  end

  assign count_o       = count_q;
  assign outstanding_o = out_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_hci_core_req_buffer.sv
// tb/tb_hci_core_req_buffer.sv - directed self-checking bench for hci_core_req_buffer
module tb_hci_core_req_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic [1:0] count;
  logic [2:0] outstanding;
  logic       err;
  int         checks = 0;
  int         errors = 0;

  hci_core_intf slv ();
  hci_core_intf mst ();

  hci_core_req_buffer dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clear_i       (clear),
    .slave         (slv),
    .master        (mst),
    .count_o       (count),
    .outstanding_o (outstanding),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    slv.req = 1'b0; slv.add = '0; slv.wen = 1'b0; slv.data = '0;
    slv.be = '0; slv.boffs = '0; slv.lrdy = 1'b0;
    mst.gnt = 1'b0; mst.r_valid = 1'b0; mst.r_data = '0;
    mst.r_opc = 1'b0; mst.r_user = '0;
  endtask

  task automatic do_clear();
    idle_inputs();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    clear = 1'b0;
    rst = 1'b1;
    mst.r_valid = 1'b1;
    slv.lrdy = 1'b1;
    #3;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (mst.req !== 1'b0) begin errors++; $display("FAIL reset_mreq got %b exp 0", mst.req); end
    checks++; if (slv.gnt !== 1'b1) begin errors++; $display("FAIL reset_sgnt got %b exp 1", slv.gnt); end
    checks++; if (slv.r_valid !== 1'b1) begin errors++; $display("FAIL reset_rvalid_pass got %b exp 1", slv.r_valid); end
    checks++; if (mst.lrdy !== 1'b1) begin errors++; $display("FAIL lrdy_pass got %b exp 1", mst.lrdy); end
    tick();
    tick();
    idle_inputs();
    rst = 1'b0;
    tick();
    checks++; if (slv.gnt !== 1'b1) begin errors++; $display("FAIL post_reset_sgnt got %b exp 1", slv.gnt); end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    slv.req = 1'b1; slv.wen = 1'b1; slv.be = 4'hF;
    slv.add = 32'h10; slv.data = 32'hA0;
    #1;
    checks++; if (slv.gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt0 got %b exp 1", slv.gnt); end
    tick();
    slv.add = 32'h14; slv.data = 32'hA1;
    #1;
    checks++; if (slv.gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt1 got %b exp 1", slv.gnt); end
    tick();
    slv.add = 32'h18; slv.data = 32'hA2;
    #1;
    checks++; if (slv.gnt !== 1'b0) begin errors++; $display("FAIL b2b_gnt2 got %b exp 0", slv.gnt); end
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL b2b_full_count got %0d exp 2", count); end
    tick();
    checks++; if (mst.add !== 32'h10) begin errors++; $display("FAIL b2b_hold_add got %h exp 10", mst.add); end
    mst.gnt = 1'b1;
    #1;
    checks++; if (mst.req !== 1'b1) begin errors++; $display("FAIL b2b_mreq got %b exp 1", mst.req); end
    checks++; if (mst.data !== 32'hA0) begin errors++; $display("FAIL b2b_data0 got %h exp a0", mst.data); end
    tick();
    checks++; if (mst.add !== 32'h14) begin errors++; $display("FAIL b2b_add1 got %h exp 14", mst.add); end
    checks++; if (slv.gnt !== 1'b1) begin errors++; $display("FAIL b2b_regrant got %b exp 1", slv.gnt); end
    tick();
    slv.req = 1'b0;
    #1;
    checks++; if (mst.add !== 32'h18) begin errors++; $display("FAIL b2b_add2 got %h exp 18", mst.add); end
    checks++; if (mst.data !== 32'hA2) begin errors++; $display("FAIL b2b_data2 got %h exp a2", mst.data); end
    checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL b2b_out2 got %0d exp 2", outstanding); end
    tick();
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL b2b_drained got %0d exp 0", count); end
    checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL b2b_out3 got %0d exp 3", outstanding); end
    checks++; if (mst.req !== 1'b0) begin errors++; $display("FAIL b2b_mreq_off got %b exp 0", mst.req); end
    mst.gnt = 1'b0;
    mst.r_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    mst.r_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL b2b_resp got %0d exp 0", outstanding); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_err got %b exp 0", err); end
  endtask

  task automatic test_outstanding_cap();
    do_clear();
    mst.gnt = 1'b1;
    slv.req = 1'b1; slv.add = 32'h40;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (slv.gnt !== 1'b1) begin errors++; $display("FAIL cap_gnt%0d got %b exp 1", i, slv.gnt); end
      tick();
    end
    checks++; if (slv.gnt !== 1'b0) begin errors++; $display("FAIL cap_full_gnt got %b exp 0", slv.gnt); end
    tick();
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL cap_out got %0d exp 4", outstanding); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL cap_count got %0d exp 0", count); end
    mst.r_valid = 1'b1;
    #1;
    checks++; if (slv.gnt !== 1'b0) begin errors++; $display("FAIL cap_same_cycle got %b exp 0", slv.gnt); end
    tick();
    mst.r_valid = 1'b0;
    slv.req = 1'b0;
    #1;
    checks++; if (slv.gnt !== 1'b1) begin errors++; $display("FAIL cap_release got %b exp 1", slv.gnt); end
    checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL cap_out3 got %0d exp 3", outstanding); end
  endtask

  task automatic test_simultaneous();
    do_clear();
    slv.req = 1'b1; slv.add = 32'h50;
    tick();
    mst.gnt = 1'b1; slv.add = 32'h54;
    tick();
    slv.add = 32'h58;
    tick();
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL sim_pre_count got %0d exp 1", count); end
    checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL sim_pre_out got %0d exp 2", outstanding); end
    slv.add = 32'h5C; mst.r_valid = 1'b1;
    #1;
    checks++; if (slv.gnt !== 1'b1) begin errors++; $display("FAIL sim_gnt got %b exp 1", slv.gnt); end
    tick();
    idle_inputs();
    #1;
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL sim_count got %0d exp 1", count); end
    checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL sim_out got %0d exp 2", outstanding); end
    checks++; if (mst.add !== 32'h5C) begin errors++; $display("FAIL sim_head got %h exp 5c", mst.add); end
    clear = 1'b1;
    #1;
    checks++; if (slv.gnt !== 1'b1) begin errors++; $display("FAIL clear_gnt got %b exp 1", slv.gnt); end
    tick();
    clear = 1'b0;
    #1;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL clear_count got %0d exp 0", count); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL clear_out got %0d exp 0", outstanding); end
    checks++; if (mst.req !== 1'b0) begin errors++; $display("FAIL clear_mreq got %b exp 0", mst.req); end
  endtask

  task automatic test_spurious();
    do_clear();
    mst.r_valid = 1'b1; mst.r_data = 32'hDEAD; mst.r_opc = 1'b1;
    #1;
    checks++; if (slv.r_data !== 32'hDEAD) begin errors++; $display("FAIL rdata_pass got %h exp dead", slv.r_data); end
    checks++; if (slv.r_opc !== 1'b1) begin errors++; $display("FAIL ropc_pass got %b exp 1", slv.r_opc); end
    tick();
    idle_inputs();
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL spur_err got %b exp 1", err); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL spur_out got %0d exp 0", outstanding); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL spur_sticky got %b exp 1", err); end
    do_clear();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL spur_clear got %b exp 0", err); end
  endtask

  task automatic test_reset_mid();
    do_clear();
    slv.req = 1'b1; slv.add = 32'h60;
    tick();
    tick();
    slv.req = 1'b0;
    #1;
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL rmid_pre got %0d exp 2", count); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (mst.req !== 1'b0) begin errors++; $display("FAIL rmid_mreq got %b exp 0", mst.req); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL rmid_count got %0d exp 0", count); end
    checks++; if (slv.gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt got %b exp 1", slv.gnt); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (mst.req !== 1'b0) begin errors++; $display("FAIL rmid_after got %b exp 0", mst.req); end
  endtask

  task automatic test_bypass();
    do_clear();
    mst.gnt = 1'b1;
    slv.req = 1'b1; slv.add = 32'h20; slv.wen = 1'b0;
    #1;
    checks++; if (slv.gnt !== 1'b1) begin errors++; $display("FAIL byp_gnt got %b exp 1", slv.gnt); end
`ifdef HCI_REQ_BUFFER_BYPASS_EN
    checks++; if (mst.req !== 1'b1) begin errors++; $display("FAIL byp_mreq got %b exp 1", mst.req); end
    checks++; if (mst.add !== 32'h20) begin errors++; $display("FAIL byp_add got %h exp 20", mst.add); end
    tick();
    slv.req = 1'b0;
    #1;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL byp_count got %0d exp 0", count); end
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL byp_out got %0d exp 1", outstanding); end
`else
    checks++; if (mst.req !== 1'b0) begin errors++; $display("FAIL lat_mreq0 got %b exp 0", mst.req); end
    tick();
    slv.req = 1'b0;
    #1;
    checks++; if (mst.req !== 1'b1) begin errors++; $display("FAIL lat_mreq1 got %b exp 1", mst.req); end
    checks++; if (mst.add !== 32'h20) begin errors++; $display("FAIL lat_add got %h exp 20", mst.add); end
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL lat_count got %0d exp 1", count); end
`endif
    do_clear();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_outstanding_cap();
    test_simultaneous();
    test_spurious();
    test_reset_mid();
    test_bypass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
